// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The loader is the slave of the byte stream and drives the memory write port.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a counted, XOR-checksummed byte image,
// writes big-endian words from address 0 and holds the core in reset until verified.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [15:0] MaxCount = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle, StHdrHi, StHdrLo, StData, StCheck, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] asm_q;
  logic [7:0]  xor_q;

  logic        byte_ready_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        cpu_reset_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  logic        accept;
  logic [15:0] count_full;
  logic [15:0] word_idx_inc;

  assign accept       = bus.byte_valid && byte_ready_q;
  assign count_full   = {count_q[15:8], bus.byte_data};
  assign word_idx_inc = word_idx_q + 16'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StError: if (start) state_d = StHdrHi;
      StHdrHi: if (accept) state_d = StHdrLo;
      StHdrLo: begin
        if (accept) begin
          if (count_full > MaxCount)   state_d = StError;
          else if (count_full == '0)   state_d = StCheck;
          else                         state_d = StData;
        end
      end
      StData: begin
        if (accept && byte_idx_q == 2'd3 && word_idx_inc == count_q) state_d = StCheck;
      end
      StCheck: begin
        if (accept) state_d = (bus.byte_data == xor_q) ? StDone : StError;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      xor_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= 1'b0;

      // Status outputs are a registered decode of the next state.
      byte_ready_q <= state_d inside {StHdrHi, StHdrLo, StData, StCheck};
      busy_q       <= state_d inside {StHdrHi, StHdrLo, StData, StCheck};
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StError);
      cpu_reset_q  <= (state_d != StDone);

      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            word_idx_q <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
          end
        end
        StHdrHi: begin
          if (accept) begin
            count_q[15:8] <= bus.byte_data;
            xor_q         <= xor_q ^ bus.byte_data;
          end
        end
        StHdrLo: begin
          if (accept) begin
            count_q[7:0] <= bus.byte_data;
            xor_q        <= xor_q ^ bus.byte_data;
          end
        end
        StData: begin
          if (accept) begin
            xor_q      <= xor_q ^ bus.byte_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {14'd0, word_idx_q, 2'b00};
              mem_wdata_q <= {asm_q, bus.byte_data};
              word_idx_q  <= word_idx_inc;
            end else begin
              asm_q <= {asm_q[15:0], bus.byte_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts the memory writes and the
// final verdict, and a per-cycle monitor checks every write strobe against it.
module tb_imem_loader;
  localparam int unsigned MaxWords = 256;
  localparam int          Budget   = 20;

  logic clk = 1'b0;
  logic reset, start;
  logic cpu_reset, busy, done, error;

  imem_loader_if bus();

  imem_loader #(.MAX_WORDS(MaxWords)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Stream-level model: header count, big-endian words, XOR over all preceding bytes.
  task automatic build_model(input logic [7:0] s[$]);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    n = int'(s[0]) * 256 + int'(s[1]);
    exp_done = 1'b0;
    if (n > int'(MaxWords)) return;
    x = s[0] ^ s[1];
    for (int i = 0; i < n; i++) begin
      w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
      x = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
      exp_addr.push_back(32'(i * 4));
      exp_data.push_back(w);
    end
    exp_done = (s[2+4*n] == x);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps, output int stalls);
    int wait_cnt;
    stalls = 0;
    foreach (s[i]) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        bus.byte_valid = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = s[i];
      wait_cnt = 0;
      while (!bus.byte_ready && wait_cnt < Budget) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt >= Budget) begin
        check_bit("accept_timeout", bus.byte_ready, 1'b1);
        bus.byte_valid = 1'b0;
        return;
      end
      stalls += wait_cnt;
      @(posedge clk);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_bit("start_busy", busy, 1'b1);
    check_bit("start_ready", bus.byte_ready, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_bit({tag, "_ready"}, bus.byte_ready, 1'b0);
    check_bit({tag, "_we"}, bus.mem_we, 1'b0);
    check({tag, "_addr"}, bus.mem_addr, 32'h0);
    check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    check_bit({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_error"}, error, 1'b0);
  endtask

  task automatic check_done_ok(input string tag);
    check_bit({tag, "_done"}, done, 1'b1);
    check_bit({tag, "_done_model"}, done, exp_done);
    check_bit({tag, "_cpu_reset"}, cpu_reset, 1'b0);
    check_bit({tag, "_error"}, error, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_ready"}, bus.byte_ready, 1'b0);
    check({tag, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  // Monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    check_bit("ready_vs_busy", bus.byte_ready, busy);
    check_bit("cpu_reset_vs_done", cpu_reset, !done);
    if (bus.mem_we === 1'b1) begin
      check_bit("write_pending", exp_addr.size() > 0, 1'b1);
      if (exp_addr.size() > 0) begin
        check("write_addr", bus.mem_addr, exp_addr.pop_front());
        check("write_data", bus.mem_wdata, exp_data.pop_front());
      end
    end
  end

  logic [7:0] s_good[$] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
  logic [7:0] s_bad[$]  = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};
  logic [7:0] s_big[$]  = '{8'h01, 8'h01};
  logic [7:0] s_zero[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] s_part[$] = '{8'h00, 8'h02, 8'h11, 8'h22};

  initial begin
    int stalls;
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    exp_done       = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("idle_cpu_reset", cpu_reset, 1'b1);
      check_bit("idle_ready", bus.byte_ready, 1'b0);
    end
    check_reset_vals("reset");

    // Good two-word image, continuous bytes; literal expectations pin the model.
    build_model(s_good);
    check("model_nwords", 32'(exp_addr.size()), 32'd2);
    check("model_addr0", exp_addr[0], 32'h0000_0000);
    check("model_data0", exp_data[0], 32'h1122_3344);
    check("model_addr1", exp_addr[1], 32'h0000_0004);
    check("model_data1", exp_data[1], 32'hAABB_CCDD);
    check_bit("model_good_done", exp_done, 1'b1);
    start_pulse();
    send_stream(s_good, 1'b0, stalls);
    check("good_stalls", 32'(stalls), 32'd0);
    check_done_ok("good");

    // Bad checksum: words still written, session ends in error.
    build_model(s_bad);
    check_bit("model_bad_done", exp_done, 1'b0);
    start_pulse();
    send_stream(s_bad, 1'b0, stalls);
    check_bit("bad_error", error, 1'b1);
    check_bit("bad_done", done, 1'b0);
    check_bit("bad_cpu_reset", cpu_reset, 1'b1);
    check_bit("bad_ready", bus.byte_ready, 1'b0);
    check("bad_writes_left", 32'(exp_addr.size()), 32'd0);

    // Oversize header 257: error right after the low byte, nothing further consumed.
    build_model(s_big);
    check("model_big_nwords", 32'(exp_addr.size()), 32'd0);
    start_pulse();
    send_stream(s_big, 1'b0, stalls);
    check_bit("big_error", error, 1'b1);
    check_bit("big_ready", bus.byte_ready, 1'b0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("big_no_accept", bus.byte_ready, 1'b0);
      check_bit("big_error_hold", error, 1'b1);
      check_bit("big_cpu_reset", cpu_reset, 1'b1);
    end
    bus.byte_valid = 1'b0;

    // Good image with a valid gap between every byte.
    build_model(s_good);
    start_pulse();
    send_stream(s_good, 1'b1, stalls);
    check_done_ok("gappy");

    // Zero-length image.
    build_model(s_zero);
    check("model_zero_nwords", 32'(exp_addr.size()), 32'd0);
    check_bit("model_zero_done", exp_done, 1'b1);
    start_pulse();
    send_stream(s_zero, 1'b0, stalls);
    check_done_ok("zero");

    // Reset mid-word: no write may escape the aborted session.
    exp_addr.delete();
    exp_data.delete();
    start_pulse();
    send_stream(s_part, 1'b0, stalls);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    build_model(s_good);
    start_pulse();
    send_stream(s_good, 1'b0, stalls);
    check_done_ok("reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
